matrix_slot_selector: RTL and testbench

Sequential, parametrised matrix-slot search and selection unit between `matrix_storage` and the operation/display FSMs. It accepts a dimension query with a match mode, scans the storage slots one per cycle, and latches a match mask and count. It then holds a cursor that the caller steps through the matching slots with wrap-around, so the user can pick an operand slot by slot.

---
 rtl/matrix_slot_selector.sv | 225 ++++++++++++++++++++++
 tb/tb_matrix_slot_selector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_slot_selector.sv
`default_nettype none
// ============================================================================
// Module   : matrix_slot_selector
// Purpose  : Scans storage slots for a dimension match, then holds a cursor
//            that steps through the matches. Define MATRIX_SEARCH_LIVE_EN to
//            prune matches whose slot_valid drops while holding.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_slot_selector #(
    parameter int MAX_STORE  = 8,
    parameter int DIM_BITS   = 4,
    parameter int IDX_BITS   = (MAX_STORE <= 1) ? 1 : $clog2(MAX_STORE),
    parameter int COUNT_BITS = ($clog2(MAX_STORE + 1) < 1) ? 1 : $clog2(MAX_STORE + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          query_valid,
    output logic                          query_ready,
    input  logic [DIM_BITS-1:0]           req_m,
    input  logic [DIM_BITS-1:0]           req_n,
    input  logic [1:0]                    req_mode,
    input  logic [MAX_STORE*DIM_BITS-1:0] stored_m_flat,
    input  logic [MAX_STORE*DIM_BITS-1:0] stored_n_flat,
    input  logic [MAX_STORE-1:0]          slot_valid,
    input  logic                          step,
    input  logic                          release_req,
    output logic                          busy,
    output logic                          done,
    output logic [MAX_STORE-1:0]          match_mask,
    output logic [COUNT_BITS-1:0]         match_count,
    output logic                          match_exists,
    output logic                          sel_valid,
    output logic [IDX_BITS-1:0]           sel_idx,
    output logic [COUNT_BITS-1:0]         sel_ordinal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] c_MODE_EXACT = 2'd0;
    localparam logic [1:0] c_MODE_TRANS = 2'd1;
    localparam logic [1:0] c_MODE_ROWS  = 2'd2;

    state_t                 r_state, w_state_nxt;
    logic [DIM_BITS-1:0]    r_req_m, r_req_n, w_req_m_nxt, w_req_n_nxt;
    logic [1:0]             r_req_mode, w_req_mode_nxt;
    logic [IDX_BITS-1:0]    r_ptr, w_ptr_nxt;
    logic [MAX_STORE-1:0]   w_mask_nxt, w_scan_mask, w_hold_mask;
    logic [COUNT_BITS-1:0]  w_count_nxt, w_scan_count, w_ord_nxt;
    logic [IDX_BITS-1:0]    w_sel_nxt, w_base_idx, w_step_idx;
    logic                   w_exists_nxt, w_done_nxt, w_hit, w_last;
    logic [DIM_BITS-1:0]    w_slot_m, w_slot_n;

    // First set bit strictly after idx, searching upward with wrap-around.
    function automatic logic [IDX_BITS-1:0] f_next_set(input logic [MAX_STORE-1:0] mask,
                                                       input logic [IDX_BITS-1:0]  idx);
        logic found;
        int   j;
        f_next_set = idx;
        found      = 1'b0;
        for (int i = 1; i <= MAX_STORE; i++) begin
            j = int'(idx) + i;
            if (j >= MAX_STORE) j = j - MAX_STORE;
            if (!found && mask[j]) begin
                f_next_set = IDX_BITS'(j);
                found      = 1'b1;
            end
        end
    endfunction

    function automatic logic [IDX_BITS-1:0] f_lowest(input logic [MAX_STORE-1:0] mask);
        f_lowest = '0;
        for (int i = MAX_STORE - 1; i >= 0; i--)
            if (mask[i]) f_lowest = IDX_BITS'(i);
    endfunction

    // Number of set bits at or below idx; a full popcount when idx is the top slot.
    function automatic logic [COUNT_BITS-1:0] f_rank(input logic [MAX_STORE-1:0] mask,
                                                     input int                   idx);
        f_rank = '0;
        for (int i = 0; i < MAX_STORE; i++)
            if (i <= idx && mask[i]) f_rank = f_rank + COUNT_BITS'(1);
    endfunction

    assign w_slot_m = stored_m_flat[int'(r_ptr)*DIM_BITS +: DIM_BITS];
    assign w_slot_n = stored_n_flat[int'(r_ptr)*DIM_BITS +: DIM_BITS];
    assign w_last   = (int'(r_ptr) == MAX_STORE - 1);

    always_comb begin
        w_hit = 1'b0;
        if (slot_valid[r_ptr]) begin
            case (r_req_mode)
                c_MODE_EXACT: w_hit = (w_slot_m == r_req_m) && (w_slot_n == r_req_n);
                c_MODE_TRANS: w_hit = (w_slot_m == r_req_n) && (w_slot_n == r_req_m);
                c_MODE_ROWS:  w_hit = (w_slot_m == r_req_m);
                default:      w_hit = (w_slot_n == r_req_n);
            endcase
        end
    end

    assign w_scan_mask  = match_mask | (w_hit ? (MAX_STORE'(1) << r_ptr) : '0);
    assign w_scan_count = match_count + (w_hit ? COUNT_BITS'(1) : COUNT_BITS'(0));

`ifdef MATRIX_SEARCH_LIVE_EN
    assign w_hold_mask = match_mask & slot_valid;
`else
    assign w_hold_mask = match_mask;
`endif

    // Invalidation of the selected slot is resolved first, then any step.
    assign w_base_idx = w_hold_mask[sel_idx] ? sel_idx : f_next_set(w_hold_mask, sel_idx);
    assign w_step_idx = step ? f_next_set(w_hold_mask, w_base_idx) : w_base_idx;

    always_comb begin
        w_state_nxt    = r_state;
        w_req_m_nxt    = r_req_m;
        w_req_n_nxt    = r_req_n;
        w_req_mode_nxt = r_req_mode;
        w_ptr_nxt      = r_ptr;
        w_mask_nxt     = match_mask;
        w_count_nxt    = match_count;
        w_exists_nxt   = match_exists;
        w_sel_nxt      = sel_idx;
        w_ord_nxt      = sel_ordinal;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (query_valid) begin
                    w_req_m_nxt    = req_m;
                    w_req_n_nxt    = req_n;
                    w_req_mode_nxt = req_mode;
                    w_ptr_nxt      = '0;
                    w_mask_nxt     = '0;
                    w_count_nxt    = '0;
                    w_exists_nxt   = 1'b0;
                    w_state_nxt    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (release_req) begin
                    w_state_nxt  = S_IDLE;
                    w_mask_nxt   = '0;
                    w_count_nxt  = '0;
                    w_exists_nxt = 1'b0;
                    w_sel_nxt    = '0;
                    w_ord_nxt    = '0;
                end else begin
                    w_mask_nxt   = w_scan_mask;
                    w_count_nxt  = w_scan_count;
                    w_exists_nxt = (w_scan_count != '0);
                    if (w_last) begin
                        w_state_nxt = S_HOLD;
                        w_done_nxt  = 1'b1;
                        w_sel_nxt   = f_lowest(w_scan_mask);
                        w_ord_nxt   = (w_scan_mask != '0) ? COUNT_BITS'(1) : COUNT_BITS'(0);
                    end else begin
                        w_ptr_nxt = r_ptr + IDX_BITS'(1);
                    end
                end
            end
            S_HOLD: begin
                if (release_req) begin
                    w_state_nxt  = S_IDLE;
                    w_mask_nxt   = '0;
                    w_count_nxt  = '0;
                    w_exists_nxt = 1'b0;
                    w_sel_nxt    = '0;
                    w_ord_nxt    = '0;
                end else if (w_hold_mask == '0) begin
                    w_mask_nxt   = '0;
                    w_count_nxt  = '0;
                    w_exists_nxt = 1'b0;
                    w_sel_nxt    = '0;
                    w_ord_nxt    = '0;
                end else begin
                    w_mask_nxt   = w_hold_mask;
                    w_count_nxt  = f_rank(w_hold_mask, MAX_STORE - 1);
                    w_exists_nxt = 1'b1;
                    w_sel_nxt    = w_step_idx;
                    w_ord_nxt    = f_rank(w_hold_mask, int'(w_step_idx));
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_m      <= '0;
            r_req_n      <= '0;
            r_req_mode   <= '0;
            r_ptr        <= '0;
            match_mask   <= '0;
            match_count  <= '0;
            match_exists <= 1'b0;
            sel_idx      <= '0;
            sel_ordinal  <= '0;
            done         <= 1'b0;
            query_ready  <= 1'b1;
            busy         <= 1'b0;
            sel_valid    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_m      <= w_req_m_nxt;
            r_req_n      <= w_req_n_nxt;
            r_req_mode   <= w_req_mode_nxt;
            r_ptr        <= w_ptr_nxt;
            match_mask   <= w_mask_nxt;
            match_count  <= w_count_nxt;
            match_exists <= w_exists_nxt;
            sel_idx      <= w_sel_nxt;
            sel_ordinal  <= w_ord_nxt;
            done         <= w_done_nxt;
            query_ready  <= (w_state_nxt == S_IDLE);
            busy         <= (w_state_nxt != S_IDLE);
            sel_valid    <= (w_state_nxt == S_HOLD) && w_exists_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_slot_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_slot_selector
// Purpose  : Directed self-checking bench for matrix_slot_selector (4 slots).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_slot_selector;

    localparam int MS = 4;
    localparam int DB = 4;
    localparam int IB = 2;
    localparam int CB = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              query_valid;
    logic              query_ready;
    logic [DB-1:0]     req_m, req_n;
    logic [1:0]        req_mode;
    logic [MS*DB-1:0]  stored_m_flat, stored_n_flat;
    logic [MS-1:0]     slot_valid;
    logic              step, release_req;
    logic              busy, done, match_exists, sel_valid;
    logic [MS-1:0]     match_mask;
    logic [CB-1:0]     match_count, sel_ordinal;
    logic [IB-1:0]     sel_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_slot_selector #(
        .MAX_STORE (MS),
        .DIM_BITS  (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .query_valid   (query_valid),
        .query_ready   (query_ready),
        .req_m         (req_m),
        .req_n         (req_n),
        .req_mode      (req_mode),
        .stored_m_flat (stored_m_flat),
        .stored_n_flat (stored_n_flat),
        .slot_valid    (slot_valid),
        .step          (step),
        .release_req   (release_req),
        .busy          (busy),
        .done          (done),
        .match_mask    (match_mask),
        .match_count   (match_count),
        .match_exists  (match_exists),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .sel_ordinal   (sel_ordinal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept at E0, then expect done only after E(MS).
    task automatic run_query(input logic [DB-1:0] m, input logic [DB-1:0] n, input logic [1:0] mode);
        req_m       = m;
        req_n       = n;
        req_mode    = mode;
        query_valid = 1'b1;
        tick();
        query_valid = 1'b0;
        check("ready_low", 32'(query_ready), 32'd0);
        repeat (MS - 1) tick();
        check("done_early", 32'(done), 32'd0);
        tick();
        check("done", 32'(done), 32'd1);
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic do_release();
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
    endtask

    initial begin
        bit seen_done;
        rst           = 1'b1;
        query_valid   = 1'b0;
        req_m         = '0;
        req_n         = '0;
        req_mode      = 2'd0;
        step          = 1'b0;
        release_req   = 1'b0;
        // slots: 0=2x3 valid, 1=3x2 valid, 2=2x3 valid, 3=2x3 invalid
        stored_m_flat = {4'd2, 4'd2, 4'd3, 4'd2};
        stored_n_flat = {4'd3, 4'd3, 4'd2, 4'd3};
        slot_valid    = 4'b0111;
        tick();
        tick();
        check("rst_ready", 32'(query_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", 32'({done, match_mask, match_count, match_exists, sel_valid, sel_idx, sel_ordinal}), 32'd0);
        rst = 1'b0;
        tick();

        // exact 2x3
        run_query(4'd2, 4'd3, 2'd0);
        check("ex_mask", 32'(match_mask), 32'b0101);
        check("ex_count", 32'(match_count), 32'd2);
        check("ex_exists", 32'(match_exists), 32'd1);
        check("ex_selv", 32'(sel_valid), 32'd1);
        check("ex_idx", 32'(sel_idx), 32'd0);
        check("ex_ord", 32'(sel_ordinal), 32'd1);
        // query ignored while holding
        req_m = 4'd5; req_n = 4'd5; query_valid = 1'b1;
        tick();
        query_valid = 1'b0;
        check("ign_done", 32'(done), 32'd0);
        check("ign_mask", 32'(match_mask), 32'b0101);
        check("ign_busy", 32'(busy), 32'd1);
        do_step();
        check("st1_idx", 32'(sel_idx), 32'd2);
        check("st1_ord", 32'(sel_ordinal), 32'd2);
        do_step();
        check("st2_idx", 32'(sel_idx), 32'd0);
        check("st2_ord", 32'(sel_ordinal), 32'd1);
        // release wins over step
        step = 1'b1; release_req = 1'b1;
        tick();
        step = 1'b0; release_req = 1'b0;
        check("rel_ready", 32'(query_ready), 32'd1);
        check("rel_clear", 32'({match_mask, match_count, match_exists, sel_valid, sel_idx, sel_ordinal}), 32'd0);

        // transposed 2x3 -> slot 1 only
        run_query(4'd2, 4'd3, 2'd1);
        check("tr_mask", 32'(match_mask), 32'b0010);
        check("tr_idx", 32'(sel_idx), 32'd1);
        do_step();
        check("tr_st_idx", 32'(sel_idx), 32'd1);
        check("tr_st_ord", 32'(sel_ordinal), 32'd1);
        do_release();

        // rows only m=2 -> slots 0,2
        run_query(4'd2, 4'd9, 2'd2);
        check("rw_mask", 32'(match_mask), 32'b0101);
        check("rw_count", 32'(match_count), 32'd2);
        do_release();

        // columns only n=2 -> slot 1
        run_query(4'd9, 4'd2, 2'd3);
        check("cl_mask", 32'(match_mask), 32'b0010);
        check("cl_idx", 32'(sel_idx), 32'd1);
        do_release();

        // no match
        run_query(4'd5, 4'd5, 2'd0);
        check("nm_exists", 32'(match_exists), 32'd0);
        check("nm_selv", 32'(sel_valid), 32'd0);
        do_step();
        check("nm_step", 32'({match_mask, match_count, sel_idx, sel_ordinal}), 32'd0);
        check("nm_busy", 32'(busy), 32'd1);
        do_release();
        check("nm_ready", 32'(query_ready), 32'd1);

        // reset two cycles into scan
        req_m = 4'd2; req_n = 4'd3; req_mode = 2'd0; query_valid = 1'b1;
        tick();
        query_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("ar_ready", 32'(query_ready), 32'd1);
        check("ar_outs", 32'({busy, done, match_mask, match_count, match_exists, sel_valid, sel_idx, sel_ordinal}), 32'd0);
        tick();
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (MS + 2) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("ar_nodone", 32'(seen_done), 32'd0);

        // slot invalidation while holding
        run_query(4'd2, 4'd3, 2'd0);
        slot_valid = 4'b0110;
        tick();
`ifdef MATRIX_SEARCH_LIVE_EN
        check("lv_mask", 32'(match_mask), 32'b0100);
        check("lv_count", 32'(match_count), 32'd1);
        check("lv_idx", 32'(sel_idx), 32'd2);
        check("lv_ord", 32'(sel_ordinal), 32'd1);
`else
        check("fz_mask", 32'(match_mask), 32'b0101);
        check("fz_count", 32'(match_count), 32'd2);
        check("fz_idx", 32'(sel_idx), 32'd0);
        check("fz_ord", 32'(sel_ordinal), 32'd1);
`endif
        slot_valid = 4'b0111;
        do_release();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
